div_result_bcd: RTL and testbench
=================================

Name: div_result_bcd

Overview:
Consumer on the result side of the div_fsm handshake. It samples `quotient` when `vld_out` pulses and converts the low BIN_W bits to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then presents the digits to the display/keypad side with a valid/ack handshake. It sits between div_fsm and the frequency display, and its only source is the divider's result bus.

Parameters:
DATAWIDTH, 59, width of the divider `quotient` bus.
BIN_W, 30, number of low quotient bits converted; matches the cymometer 30-bit frequency range.
DIGITS, 10, number of BCD digits output; 4*DIGITS must cover 2^BIN_W-1.

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst  in  1  synchronous, active-high reset.
vld_out  in  1  divider result-valid pulse, one cycle.
quotient  in  DATAWIDTH  divider quotient; valid only when vld_out=1.
bcd_out  out  4*DIGITS  packed BCD; digit 0 in [3:0]; most significant digit at top.
bcd_vld  out  1  bcd_out holds a new, unacknowledged result.
bcd_ack  in  1  consumer accepts bcd_out when high together with bcd_vld.
ovf  out  1  current bcd_out is saturated: quotient[DATAWIDTH-1:BIN_W] was nonzero.
busy  out  1  conversion in progress (state SHIFT).
drop  out  1  sticky: a sampled result was overwritten before it was converted.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On sys_rst=1 at a rising edge:
  - bcd_out=0, bcd_vld=0, ovf=0, busy=0, drop=0.
  - Pending register is cleared; state goes to IDLE; the shift counter goes to 0.
  - This holds even mid-conversion. The partial result is discarded and no bcd_vld follows.
- States:
  - IDLE: waiting for a result.
  - SHIFT: conversion running; busy=1.
  - HOLD: bcd_vld=1, waiting for bcd_ack.
- IDLE:
  - vld_out=1 at edge N → load bin=quotient[BIN_W-1:0] and ovf_nxt=|quotient[DATAWIDTH-1:BIN_W]; clear the BCD accumulator; cnt=0; go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - cnt increments each cycle.
  - After exactly BIN_W iterations (edges N+1..N+BIN_W), the same edge sets bcd_vld=1 and state=HOLD.
  - That edge loads bcd_out with the accumulator, or with all digits 4'h9 if ovf_nxt. It also loads ovf=ovf_nxt.
  - Latency: bcd_vld is visible after edge N+BIN_W, i.e. 30 cycles.
- bcd_out and ovf change only at that loading edge. They hold their value through HOLD and after ack until the next completion.
- HOLD:
  - bcd_vld stays 1 until an edge with bcd_ack=1; bcd_vld falls at that edge.
  - At the ack edge, if a start source exists, go directly to SHIFT with no IDLE bubble. Otherwise go to IDLE.
  - bcd_ack while bcd_vld=0 is ignored.
- Start sources, at an IDLE edge or an ack edge, in priority order:
  - Live vld_out first. If the pending register is also valid at that edge, it is discarded and drop=1.
  - Otherwise the pending register, which is cleared when it starts.
- vld_out in SHIFT, or in HOLD without ack:
  - The value is captured into a one-deep pending register (quotient slice plus overflow flag); newest wins.
  - If pending was already valid, drop=1.
- drop clears only on reset.
- Arithmetic:
  - The accumulator is 4*DIGITS bits; the add-3 applies per nibble, unsigned, with no carry between nibbles.
  - Overflow path still runs BIN_W cycles, so latency is uniform.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/SHIFT/HOLD);
  - the BCD nibble constant 4'h9 used for saturation;
  - the threshold 4'd5 and the add constant 4'd3.
- One natural sub-module: bcd_add3_stage, combinational. It applies the conditional +3 across all DIGITS nibbles and is instantiated once inside the SHIFT datapath.

Test Plan:
- Reset, then vld_out with quotient=20_000_000, bcd_ack held 1 → bcd_out=40'h0020000000, ovf=0, bcd_vld high exactly 30 cycles after the sampling edge for one cycle.
- quotient=0, then quotient=2^30-1 (1_073_741_823) → bcd_out=40'h0000000000, then 40'h1073741823.
- quotient=2^30 (bit 30 set) → bcd_out=40'h9999999999, ovf=1; the next quotient=5 → 40'h0000000005, ovf=0.
- Hold mode with bcd_ack=0:
  - Result A=100 completes; B=200 and then C=300 pulse during conversion/HOLD.
  - Expect drop=1 and bcd_out stays 40'h0000000100 until ack.
  - On ack, conversion restarts the same edge; next bcd_out=40'h0000000300.
- Simultaneous:
  - bcd_ack and vld_out (D=7) on the same edge while pending E=9 is valid → D converts, E discarded, drop=1, next bcd_out=40'h0000000007.
  - Then apply sys_rst at cycle 10 of a conversion → all outputs 0 next edge, no bcd_vld within 40 cycles.

Source files
------------

// File: rtl/div_result_bcd_pkg.sv
// Shared types and constants for the divider-result to packed-BCD converter.
package div_result_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE   = 4'h9;
    localparam logic [3:0] BCD_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADD3   = 4'd3;

endpackage

// File: rtl/div_result_bcd_add3_stage.sv
// Combinational double-dabble correction: every nibble >= 5 gets +3, no inter-nibble carry.
module bcd_add3_stage
    import div_result_bcd_pkg::*;
#(
    parameter int DIGITS = 10
) (
    input  logic [DIGITS-1:0][3:0] din,
    output logic [DIGITS-1:0][3:0] dout
);

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign dout[g] = (din[g] >= BCD_THRESH) ? din[g] + BCD_ADD3 : din[g];
    end

endmodule

// File: rtl/div_result_bcd.sv
// Samples the divider quotient, converts the low BIN_W bits to packed BCD serially,
// and presents the result with a valid/ack handshake plus a one-deep pending slot.
module div_result_bcd
    import div_result_bcd_pkg::*;
#(
    parameter int DATAWIDTH = 59,
    parameter int BIN_W     = 30,
    parameter int DIGITS    = 10
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    vld_out,
    input  logic [DATAWIDTH-1:0]    quotient,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic                    bcd_vld,
    input  logic                    bcd_ack,
    output logic                    ovf,
    output logic                    busy,
    output logic                    drop
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef struct packed {
        logic             vld;
        logic             ovf;
        logic [BIN_W-1:0] bin;
    } pend_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    bin_sh;
    logic [4*DIGITS-1:0] acc, acc_adj, acc_shl;
    logic                ovf_nxt;
    pend_t               pend, live, src;
    logic                start_ok, start_live, start_pend, start_any, capture, last_iter;

    assign live = {1'b1, |quotient[DATAWIDTH-1:BIN_W], quotient[BIN_W-1:0]};
    assign src  = vld_out ? live : pend;

    // A new conversion may begin from IDLE or on the very edge the held result is acked.
    assign start_ok   = (state == ST_IDLE) || (state == ST_HOLD && bcd_ack);
    assign start_live = start_ok && vld_out;
    assign start_pend = start_ok && !vld_out && pend.vld;
    assign start_any  = start_live || start_pend;
    assign capture    = vld_out && !start_ok;
    assign last_iter  = (state == ST_SHIFT) && (cnt == CNT_W'(BIN_W - 1));

    bcd_add3_stage #(.DIGITS(DIGITS)) u_add3 (
        .din  (acc),
        .dout (acc_adj)
    );

    assign acc_shl = {acc_adj[4*DIGITS-2:0], bin_sh[BIN_W-1]};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_any) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_iter) state_nxt = ST_HOLD;
            ST_HOLD:  if (bcd_ack)   state_nxt = start_any ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt     <= '0;
            bin_sh  <= '0;
            acc     <= '0;
            ovf_nxt <= 1'b0;
            pend    <= '0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            drop    <= 1'b0;
        end else begin
            if (start_any) begin
                bin_sh  <= src.bin;
                ovf_nxt <= src.ovf;
                acc     <= '0;
                cnt     <= '0;
            end else if (state == ST_SHIFT) begin
                {acc, bin_sh} <= {acc_adj, bin_sh} << 1;
                cnt           <= cnt + 1'b1;
            end

            if (last_iter) begin
                bcd_out <= ovf_nxt ? {DIGITS{BCD_NINE}} : acc_shl;
                ovf     <= ovf_nxt;
            end

            // Newest result wins the pending slot; a live start discards whatever was waiting.
            if (capture)        pend <= live;
            else if (start_any) pend <= '0;

            if ((capture || start_live) && pend.vld) drop <= 1'b1;
        end
    end

    assign bcd_vld = (state == ST_HOLD);
    assign busy    = (state == ST_SHIFT);

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_div_result_bcd;

    localparam int DW = 59;
    localparam int BW = 30;
    localparam int DG = 10;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            vld_out = 1'b0;
    logic            bcd_ack = 1'b0;
    logic [DW-1:0]   quotient = '0;
    logic [4*DG-1:0] bcd_out;
    logic            bcd_vld, ovf, busy, drop;

    div_result_bcd #(.DATAWIDTH(DW), .BIN_W(BW), .DIGITS(DG)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .vld_out  (vld_out),
        .quotient (quotient),
        .bcd_out  (bcd_out),
        .bcd_vld  (bcd_vld),
        .bcd_ack  (bcd_ack),
        .ovf      (ovf),
        .busy     (busy),
        .drop     (drop)
    );

    always #10 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: mode 0 idle, 1 converting, 2 holding a result.
    int              m_mode = 0;
    int              m_left = 0;
    logic [BW-1:0]   m_val  = '0;
    logic            m_cov  = 1'b0;
    logic            p_v    = 1'b0;
    logic [BW-1:0]   p_val  = '0;
    logic            p_ovf  = 1'b0;
    logic [4*DG-1:0] m_bcd  = '0;
    logic            m_ovf  = 1'b0;
    logic            m_drop = 1'b0;

    function automatic logic [4*DG-1:0] to_bcd(input longint unsigned v);
        logic [4*DG-1:0] r = '0;
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        bit so;
        if (sys_rst) begin
            m_mode = 0; m_left = 0; p_v = 1'b0;
            m_bcd = '0; m_ovf = 1'b0; m_drop = 1'b0;
            return;
        end
        so = (m_mode == 0) || (m_mode == 2 && bcd_ack);
        if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 2;
                m_bcd  = m_cov ? 40'h9999999999 : to_bcd(longint'(m_val));
                m_ovf  = m_cov;
            end
        end else if (m_mode == 2 && bcd_ack) begin
            m_mode = 0;
        end
        if (so) begin
            if (vld_out) begin
                if (p_v) m_drop = 1'b1;
                p_v = 1'b0;
                m_mode = 1; m_left = BW;
                m_val = quotient[BW-1:0]; m_cov = |quotient[DW-1:BW];
            end else if (p_v) begin
                p_v = 1'b0;
                m_mode = 1; m_left = BW;
                m_val = p_val; m_cov = p_ovf;
            end
        end else if (vld_out) begin
            if (p_v) m_drop = 1'b1;
            p_v = 1'b1; p_val = quotient[BW-1:0]; p_ovf = |quotient[DW-1:BW];
        end
    endtask

    task automatic compare_all();
        chk("bcd_out", bcd_out, m_bcd);
        chk("bcd_vld", bcd_vld, m_mode == 2);
        chk("busy",    busy,    m_mode == 1);
        chk("ovf",     ovf,     m_ovf);
        chk("drop",    drop,    m_drop);
    endtask

    task automatic cyc(input bit v, input logic [DW-1:0] q, input bit a, input bit r);
        vld_out = v; quotient = q; bcd_ack = a; sys_rst = r;
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic wait_vld(input bit a, output int lat);
        lat = 0;
        do begin
            cyc(1'b0, '0, a, 1'b0);
            lat++;
        end while (!bcd_vld && lat < 40);
        chk("vld_seen", bcd_vld, 1'b1);
    endtask

    task automatic conv(input string name, input logic [DW-1:0] q,
                        input logic [4*DG-1:0] exp_bcd, input bit exp_ovf);
        int lat;
        cyc(1'b1, q, 1'b1, 1'b0);
        wait_vld(1'b1, lat);
        chk({name, "_latency"}, lat, 30);
        chk({name, "_bcd"}, bcd_out, exp_bcd);
        chk({name, "_ovf"}, ovf, exp_ovf);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk({name, "_vld_fall"}, bcd_vld, 1'b0);
        chk({name, "_bcd_held"}, bcd_out, exp_bcd);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [DW-1:0] q;

        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("rst_bcd_out", bcd_out, 0);
        chk("rst_bcd_vld", bcd_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop, 0);

        conv("q20m",  DW'(20_000_000),     40'h0020000000, 1'b0);
        conv("qzero", '0,                  40'h0000000000, 1'b0);
        conv("qmax",  DW'(1_073_741_823),  40'h1073741823, 1'b0);
        conv("qovf",  DW'(64'd1 << 30),    40'h9999999999, 1'b1);
        conv("q5",    DW'(5),              40'h0000000005, 1'b0);

        // Hold with no ack while two more results arrive.
        cyc(1'b1, DW'(100), 1'b0, 1'b0);
        repeat (5) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, DW'(200), 1'b0, 1'b0);
        wait_vld(1'b0, lat);
        chk("hold_a_bcd", bcd_out, 40'h0000000100);
        chk("hold_no_drop_yet", drop, 0);
        cyc(1'b1, DW'(300), 1'b0, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("hold_drop", drop, 1);
        chk("hold_bcd_kept", bcd_out, 40'h0000000100);
        chk("hold_vld_kept", bcd_vld, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("restart_busy", busy, 1);
        chk("restart_vld", bcd_vld, 0);
        wait_vld(1'b1, lat);
        chk("restart_latency", lat, 30);
        chk("hold_c_bcd", bcd_out, 40'h0000000300);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Ack and live result on the same edge with a pending result waiting.
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("rst2_drop", drop, 0);
        cyc(1'b1, DW'(1), 1'b0, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, DW'(9), 1'b0, 1'b0);
        wait_vld(1'b0, lat);
        chk("sim_pre_drop", drop, 0);
        cyc(1'b1, DW'(7), 1'b1, 1'b0);
        chk("sim_drop", drop, 1);
        chk("sim_busy", busy, 1);
        wait_vld(1'b1, lat);
        chk("sim_bcd", bcd_out, 40'h0000000007);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Reset in the middle of a conversion.
        cyc(1'b1, DW'(123), 1'b0, 1'b0);
        repeat (9) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("midrst_bcd", bcd_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_drop", drop, 0);
        seen = 1'b0;
        repeat (40) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            if (bcd_vld) seen = 1'b1;
        end
        chk("midrst_no_vld", seen, 0);

        // Randomized traffic.
        repeat (3000) begin
            q = DW'({$urandom, $urandom});
            if ($urandom_range(0, 3) != 0) q[DW-1:BW] = '0;
            cyc($urandom_range(0, 7) == 0, q, $urandom_range(0, 1) == 1,
                $urandom_range(0, 499) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
